uart_tx: RTL and testbench

- UART transmitter: the transmit counterpart of the existing instruction-loading UART receiver in the wrapper.
- Serialises bytes onto a single line, 8N1 by default, LSB first.
- A small byte FIFO lets the core or a debug path push words byte-wise without stalling on every byte.
- Sits in the wrapper next to the receiver and uses the same clk and bit-rate parameters, so an rx/tx loopback is possible.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing helpers and the
// default clock / bit-rate settings used by both the receiver and transmitter.
package uart_pkg;

  localparam int unsigned UART_BIT_RATE_DFLT = 9600;
  localparam int unsigned UART_CLK_HZ_DFLT   = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: show-ahead head, power-of-two
// depth so the pointers wrap for free.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, 1 or 2 stop bits, fed by a small byte FIFO.
// Define UART_TX_PARITY_EN to insert a parity bit after the payload.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = UART_BIT_RATE_DFLT,
  parameter int unsigned CLK_HZ       = UART_CLK_HZ_DFLT,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic                    uart_tx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_ready,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int unsigned CPB      = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CW       = cnt_width(CPB);
  localparam int unsigned BMAX     = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
  localparam int unsigned BW       = cnt_width(BMAX);
  localparam int unsigned FAW      = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1 || CPB < 1) begin : g_bad_cfg
    $error("uart_tx: illegal STOP_BITS, PARITY_ODD or bit-rate setting");
  end

  uart_state_e             state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d, shreg_nx;
  logic                    txd_q, txd_d;
  logic                    bit_end, start_ok, launch;

  logic [PAYLOAD_BITS-1:0] head;
  logic                    fifo_full, fifo_empty;
  logic [FAW:0]            fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAYLOAD_BITS)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (uart_tx_valid),
    .wr_data (uart_tx_data),
    .rd_en   (launch),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign uart_tx_ready = ~fifo_full;
  assign uart_tx_busy  = (state_q != ST_IDLE) | (fifo_count != '0);
  assign uart_txd      = txd_q;

  assign bit_end  = (cyc_q == '0);
  assign start_ok = uart_tx_en & ~fifo_empty;
  assign shreg_nx = shreg_q >> 1;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    launch  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (!bit_end) cyc_d = cyc_q - CW'(1);

    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        launch = start_ok;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        cyc_d   = CYC_LAST;
        bit_d   = '0;
        txd_d   = shreg_q[0];
      end
      ST_DATA: if (bit_end) begin
        cyc_d = CYC_LAST;
        if (bit_q == DATA_LAST) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
          txd_d   = par_q;
`else
          state_d = ST_STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + BW'(1);
          shreg_d = shreg_nx;
          txd_d   = shreg_nx[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        cyc_d   = CYC_LAST;
        bit_d   = '0;
        txd_d   = 1'b1;
      end
`endif
      ST_STOP: if (bit_end) begin
        if (bit_q == STOP_LAST) begin
          // Back-to-back frames: the next start bit follows the last stop bit directly.
          if (start_ok) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          bit_d = bit_q + BW'(1);
          cyc_d = CYC_LAST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (launch) begin
      state_d = ST_START;
      cyc_d   = CYC_LAST;
      bit_d   = '0;
      shreg_d = head;
      txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ ODD;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor
// decodes frames off uart_txd and checks every bit level and duration.
module tb_uart_tx;

  localparam int CLK_HZ   = 80;
  localparam int BIT_RATE = 10;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int STOPB    = 1;
  localparam int PAR_ODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 1 + 8 + 1 + STOPB;
`else
  localparam int NBITS = 1 + 8 + STOPB;
`endif
  localparam int F    = NBITS * CPB;
  localparam int MAXW = 20 * F;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_tx_en;
  logic       uart_tx_valid;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ready;
  logic       uart_tx_busy;
  logic       uart_txd;

  uart_tx #(
    .BIT_RATE     (BIT_RATE),
    .CLK_HZ       (CLK_HZ),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (STOPB),
    .FIFO_DEPTH   (4),
    .PARITY_ODD   (PAR_ODD)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_busy  (uart_tx_busy),
    .uart_txd      (uart_txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         starts[$];
  logic       mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Line monitor: pops the expected byte at each start bit and checks the frame.
  logic [15:0] fb;
  logic [7:0]  mb;
  logic        bad_v, aborted;
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=start_bit expected=idle (cycle %0d)", cyc);
          while (uart_txd === 1'b0 && resetn === 1'b1) @(negedge clk);
        end else begin
          mb = exp_q.pop_front();
          mon_busy = 1'b1;
          starts.push_back(cyc);
          fb = '1;
          fb[0] = 1'b0;
          for (int k = 0; k < 8; k++) fb[1+k] = mb[k];
`ifdef UART_TX_PARITY_EN
          fb[9] = (^mb) ^ PAR_ODD[0];
`endif
          aborted = 1'b0;
          for (int i = 0; i < NBITS; i++) begin
            bad_v = fb[i];
            for (int c = 0; c < CPB; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (resetn !== 1'b1) aborted = 1'b1;
              else if (uart_txd !== fb[i]) bad_v = uart_txd;
              if (aborted) break;
            end
            if (aborted) break;
            chk($sformatf("frame_%02h_bit%0d", mb, i), 32'(bad_v), 32'(fb[i]));
          end
          if (!aborted) got_q.push_back(mb);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    uart_tx_data  = b;
    uart_tx_valid = 1'b1;
    while (uart_tx_ready !== 1'b1 && n < MAXW) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(uart_tx_ready), 32'd1);
    exp_q.push_back(b);
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < MAXW) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < MAXW), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int acc, acc0, acc6, base, s0;
  logic [7:0] bb [0:5];

  initial begin
    resetn        = 1'b0;
    uart_tx_en    = 1'b0;
    uart_tx_valid = 1'b0;
    uart_tx_data  = 8'h00;

    // Reset state
    #4000;
    @(negedge clk);
    chk("rst_txd",   32'(uart_txd),      32'd1);
    chk("rst_busy",  32'(uart_tx_busy),  32'd0);
    chk("rst_ready", 32'(uart_tx_ready), 32'd1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5: start latency and busy fall
    uart_tx_en = 1'b1;
    base = starts.size();
    push(8'hA5, acc);
    uart_tx_valid = 1'b0;
    chk("t1_busy_early", 32'(uart_tx_busy), 32'd1);
    wait_cyc(acc + F);
    chk("t1_busy_last", 32'(uart_tx_busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_fall", 32'(uart_tx_busy), 32'd0);
    drain("t1_drain");
    chk("t1_start_lat", 32'(starts[base]), 32'(acc + 1));

    // Back-to-back with backpressure
    bb[0] = 8'h00; bb[1] = 8'h13; bb[2] = 8'h01;
    bb[3] = 8'h01; bb[4] = 8'hFF; bb[5] = 8'h10;
    base = starts.size();
    got_q.delete();
    push(bb[0], acc0);
    for (int i = 1; i < 5; i++) push(bb[i], acc);
    chk("t2_ready_full", 32'(uart_tx_ready), 32'd0);
    push(bb[5], acc6);
    uart_tx_valid = 1'b0;
    chk("t2_accept6", 32'(acc6), 32'(acc0 + 1 + F + 1));
    drain("t2_drain");
    for (int i = 0; i < 6; i++) chk($sformatf("t2_order%0d", i), 32'(got_q[i]), 32'(bb[i]));
    for (int i = 1; i < 6; i++)
      chk($sformatf("t2_gap%0d", i), 32'(starts[base+i] - starts[base+i-1]), 32'(F));

    // Enable gating
    base = starts.size();
    push(8'h5A, acc0);
    push(8'hC3, acc);
    push(8'h07, acc);
    uart_tx_valid = 1'b0;
    s0 = acc0 + 1;
    wait_cyc(s0 + 3*CPB);
    uart_tx_en = 1'b0;
    wait_cyc(s0 + F + 2*CPB);
    chk("t3_line_idle", 32'(uart_txd),      32'd1);
    chk("t3_busy_held", 32'(uart_tx_busy),  32'd1);
    chk("t3_queued",    32'(exp_q.size()),  32'd2);
    uart_tx_en = 1'b1;
    drain("t3_drain");
    chk("t3_f2_start", 32'(starts[base+1]), 32'(s0 + F + 2*CPB + 1));
    chk("t3_f3_gap",   32'(starts[base+2] - starts[base+1]), 32'(F));

    // Word 0xff010113 LSB byte first, decoded by the line monitor
    got_q.delete();
    push(8'h13, acc);
    push(8'h01, acc);
    push(8'h01, acc);
    push(8'hFF, acc);
    uart_tx_valid = 1'b0;
    drain("t4_drain");
    chk("t4_cnt",  32'(got_q.size()), 32'd4);
    chk("t4_b0",   32'(got_q[0]), 32'h13);
    chk("t4_b1",   32'(got_q[1]), 32'h01);
    chk("t4_b2",   32'(got_q[2]), 32'h01);
    chk("t4_b3",   32'(got_q[3]), 32'hFF);

    // Reset mid-DATA: line high at once, frame and queue discarded
    push(8'h3C, acc0);
    push(8'h55, acc);
    push(8'h66, acc);
    uart_tx_valid = 1'b0;
    wait_cyc(acc0 + 1 + 2*CPB + 3);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_txd_async", 32'(uart_txd), 32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t5_busy",  32'(uart_tx_busy),  32'd0);
    chk("t5_ready", 32'(uart_tx_ready), 32'd1);
    repeat (2*F) @(negedge clk);
    chk("t5_quiet_txd",  32'(uart_txd),     32'd1);
    chk("t5_quiet_busy", 32'(uart_tx_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
